// File: rtl/z80_bus_pkg.sv
// ============================================================================
//  Module   : z80_bus_pkg
//  Brief    : Shared types and constants for the Z80 bus responder.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package z80_bus_pkg;

    typedef enum logic [1:0] {
        DRAIN = 2'd0,
        IDLE  = 2'd1,
        REQ   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int         c_cnt_w      = 16;
    localparam logic [7:0] c_abort_data = 8'hFF;

endpackage

`default_nettype wire

// File: rtl/z80_bus_decode.sv
// ============================================================================
//  Module   : z80_bus_decode
//  Brief    : Combinational classifier for Z80 memory, I/O and INTA cycles.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module z80_bus_decode #(
    parameter logic [15:0] MEM_MATCH = 16'h0000,
    parameter logic [15:0] MEM_MASK  = 16'h0000,
    parameter int          IO_EN     = 1
) (
    input  logic [15:0] i_addr,
    input  logic        i_m1_n,
    input  logic        i_mreq_n,
    input  logic        i_iorq_n,
    input  logic        i_rd_n,
    input  logic        i_wr_n,
    input  logic        i_rfsh_n,
    output logic        o_mem_hit,
    output logic        o_io_hit,
    output logic        o_inta,
    output logic        o_is_read
);

    localparam logic c_io_en = (IO_EN != 0);

    logic w_rw;
    logic w_addr_match;

    assign w_rw         = !i_rd_n || !i_wr_n;
    assign w_addr_match = ((i_addr & MEM_MASK) == MEM_MATCH);

    // Refresh cycles drive MREQ low too; rfsh_n keeps them from being claimed.
    assign o_mem_hit = !i_mreq_n && i_rfsh_n && w_rw && w_addr_match;
    assign o_io_hit  = c_io_en && !i_iorq_n && i_m1_n && w_rw;
    assign o_inta    = !i_iorq_n && !i_m1_n;
    assign o_is_read = !i_rd_n;

endmodule

`default_nettype wire

// File: rtl/z80_bus_responder.sv
// ============================================================================
//  Module   : z80_bus_responder
//  Brief    : Target-side Z80 bus agent bridging CPU cycles to a req/ack backend.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module z80_bus_responder
    import z80_bus_pkg::*;
#(
    parameter logic [15:0] MEM_MATCH = 16'h0000,
    parameter logic [15:0] MEM_MASK  = 16'h0000,
    parameter int          IO_EN     = 1,
    parameter int          TIMEOUT   = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [15:0] A,
    input  logic [7:0]  di,
    input  logic        m1_n,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        rfsh_n,
    output logic [7:0]  dout,
    output logic        doe,
    output logic        wait_n,
    output logic        int_n,
    input  logic        irq_req,
    input  logic [7:0]  irq_vector,
    output logic        irq_ack,
    output logic        bk_req,
    output logic        bk_we,
    output logic        bk_io,
    output logic [15:0] bk_addr,
    output logic [7:0]  bk_wdata,
    input  logic [7:0]  bk_rdata,
    input  logic        bk_ack,
    output logic        timeout
);

    localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(TIMEOUT - 1);

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [7:0]           r_dout;
    logic                 r_int_n;
    logic                 r_irq_ack;
    logic                 r_bk_req;
    logic                 r_bk_we;
    logic                 r_bk_io;
    logic [15:0]          r_bk_addr;
    logic [7:0]           r_bk_wdata;
    logic                 r_timeout;
    logic                 r_inta;
    logic                 r_rd;

    logic w_mem_hit;
    logic w_io_hit;
    logic w_inta;
    logic w_is_read;
    logic w_hit;
    logic w_strobe_low;

    z80_bus_decode #(
        .MEM_MATCH (MEM_MATCH),
        .MEM_MASK  (MEM_MASK),
        .IO_EN     (IO_EN)
    ) u_decode (
        .i_addr    (A),
        .i_m1_n    (m1_n),
        .i_mreq_n  (mreq_n),
        .i_iorq_n  (iorq_n),
        .i_rd_n    (rd_n),
        .i_wr_n    (wr_n),
        .i_rfsh_n  (rfsh_n),
        .o_mem_hit (w_mem_hit),
        .o_io_hit  (w_io_hit),
        .o_inta    (w_inta),
        .o_is_read (w_is_read)
    );

    assign w_hit = w_mem_hit || w_io_hit || w_inta;

    // The strobe that opened the current cycle: IORQ for I/O and INTA, else MREQ.
    assign w_strobe_low = (r_bk_io || r_inta) ? !iorq_n : !mreq_n;

    always_comb begin
        wait_n = 1'b1;
        doe    = 1'b0;
        case (r_state)
            IDLE:    wait_n = !(w_hit && !w_inta);
            REQ:     wait_n = 1'b0;
            DONE: begin
                if (r_inta)
                    doe = !iorq_n;
                else
                    doe = r_rd && !rd_n && w_strobe_low;
            end
            default: wait_n = 1'b1;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state    <= DRAIN;
            r_cnt      <= '0;
            r_dout     <= 8'h00;
            r_int_n    <= 1'b1;
            r_irq_ack  <= 1'b0;
            r_bk_req   <= 1'b0;
            r_bk_we    <= 1'b0;
            r_bk_io    <= 1'b0;
            r_bk_addr  <= 16'h0000;
            r_bk_wdata <= 8'h00;
            r_timeout  <= 1'b0;
            r_inta     <= 1'b0;
            r_rd       <= 1'b0;
        end else begin
            r_int_n   <= !irq_req;
            r_irq_ack <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                DRAIN: begin
                    if (mreq_n && iorq_n)
                        r_state <= IDLE;
                end
                IDLE: begin
                    if (w_inta) begin
                        r_dout    <= irq_vector;
                        r_irq_ack <= 1'b1;
                        r_inta    <= 1'b1;
                        r_rd      <= 1'b0;
                        r_state   <= DONE;
                    end else if (w_mem_hit || w_io_hit) begin
                        r_bk_addr  <= A;
                        r_bk_wdata <= di;
                        r_bk_we    <= !wr_n;
                        r_bk_io    <= w_io_hit;
                        r_bk_req   <= 1'b1;
                        r_inta     <= 1'b0;
                        r_rd       <= w_is_read;
                        r_cnt      <= '0;
                        r_state    <= REQ;
                    end
                end
                REQ: begin
                    // An ack arriving on the expiry cycle still wins over the abort.
                    if (bk_ack) begin
                        r_bk_req <= 1'b0;
                        if (r_rd)
                            r_dout <= bk_rdata;
                        r_state <= DONE;
                    end else if (r_cnt == c_timeout_last) begin
                        r_bk_req  <= 1'b0;
                        r_dout    <= c_abort_data;
                        r_timeout <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (!w_strobe_low)
                        r_state <= IDLE;
                end
                default: r_state <= DRAIN;
            endcase
        end
    end

    assign dout     = r_dout;
    assign int_n    = r_int_n;
    assign irq_ack  = r_irq_ack;
    assign bk_req   = r_bk_req;
    assign bk_we    = r_bk_we;
    assign bk_io    = r_bk_io;
    assign bk_addr  = r_bk_addr;
    assign bk_wdata = r_bk_wdata;
    assign timeout  = r_timeout;

endmodule

`default_nettype wire

// File: doc/z80_bus_responder.md
Name: z80_bus_responder

Overview:
- Target-side Z80 bus agent. Sits on the CPU pins opposite the z80 core, in the same wb_clk_i domain.
- Decodes MREQ/IORQ/RD/WR/M1 bus cycles and forwards memory and I/O accesses to a req/ack backend (SRAM, peripherals).
- Holds the CPU with wait_n until the backend answers, and drives read data onto the bidirectional data bus.
- Also generates int_n and supplies the IM2 vector during interrupt-acknowledge cycles.

Parameters:
- MEM_MATCH, 16'h0000: memory window base; a hit is (A & MEM_MASK) == MEM_MATCH.
- MEM_MASK, 16'h0000: memory window mask; the default 0 claims all memory.
- IO_EN, 1: 1 = respond to I/O cycles; 0 = ignore them.
- TIMEOUT, 255: max cycles spent in REQ before abort; range 1..65535.

Ports:
- wb_clk_i  in  1  clock; the CPU runs on the same clock.
- wb_rst_i  in  1  asynchronous, active-high reset.
- A  in  16  CPU address bus.
- di  in  8  CPU data out (write data).
- m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n  in  1 each  CPU control strobes.
- dout  out  8  read data toward the CPU.
- doe  out  1  data bus drive enable.
- wait_n  out  1  CPU wait request.
- int_n  out  1  CPU maskable interrupt.
- irq_req  in  1  level interrupt request from a peripheral.
- irq_vector  in  8  IM2 vector.
- irq_ack  out  1  one-cycle pulse on completion of INTA.
- bk_req  out  1  backend request.
- bk_we  out  1  backend write.
- bk_io  out  1  1 = I/O space.
- bk_addr  out  16  backend address; I/O cycles use the full A.
- bk_wdata  out  8  backend write data.
- bk_rdata  in  8  backend read data.
- bk_ack  in  1  backend completion.
- timeout  out  1  one-cycle pulse when an access is aborted.

Behaviour:
- Reset (async, wb_rst_i=1): state=DRAIN.
  - Outputs: wait_n=1, int_n=1, doe=0, dout=0, bk_req=0, bk_we=0, bk_io=0, bk_addr=0, bk_wdata=0, irq_ack=0, timeout=0, timeout counter=0.
- Decode (combinational):
  - mem_hit = !mreq_n & rfsh_n & (!rd_n | !wr_n) & addr match.
  - io_hit = IO_EN & !iorq_n & m1_n & (!rd_n | !wr_n).
  - inta = !iorq_n & !m1_n.
  - hit = mem_hit | io_hit | inta.
  - Refresh cycles (rfsh_n=0) and memory misses are ignored: no wait, doe=0.
- State DRAIN: wait_n=1. Go to IDLE once mreq_n & iorq_n are both high. This guarantees no half cycle is served after reset.
- State IDLE:
  - On mem_hit or io_hit: latch A, di, bk_we=!wr_n, bk_io=io_hit; assert bk_req next cycle; go to REQ.
  - On inta: dout<=irq_vector; go to DONE; irq_ack pulses 1 cycle.
  - wait_n = !(hit & !inta) combinationally in IDLE, so the CPU is held in the same cycle it presents the strobe. INTA never waits.
- State REQ:
  - bk_req=1 and wait_n=0. Backend address, data and control stay stable until ack.
  - On bk_ack=1: bk_req<=0. For a read, dout<=bk_rdata. Go to DONE.
  - If the counter reaches TIMEOUT first: bk_req<=0, dout<=8'hFF, timeout pulse, go to DONE.
  - bk_ack and timeout in the same cycle: ack wins, no timeout pulse.
  - The counter clears on REQ entry.
- State DONE:
  - wait_n=1. doe = !rd_n for reads/INTA, else 0; doe drops combinationally as soon as rd_n or iorq_n deasserts.
  - Stay in DONE until the active strobe (mreq_n or iorq_n) rises, then go to IDLE.
- Strobes withdrawn during REQ (a CPU reset): finish the backend handshake, then go to DONE, which exits immediately.
- Latency: read data reaches dout 1 cycle after bk_ack; wait_n releases in that same cycle.
- int_n = !irq_req, registered (1-cycle delay). irq_ack is independent of irq_req deassertion.
- bk_ack outside REQ is ignored.

Decomposition:
- Shared package z80_bus_pkg:
  - state enum {DRAIN, IDLE, REQ, DONE}.
  - TIMEOUT counter width (16).
  - Abort data constant 8'hFF.
- One sub-module, z80_bus_decode: combinational cycle classifier producing mem_hit, io_hit, inta and is_read.
- FSM, counter and backend registers live in the top.

Test Plan:
- Memory read at A=16'h1234, bk_ack 3 cycles after bk_req, bk_rdata=8'hA5 -> wait_n low in the strobe cycle; bk_addr=1234, bk_we=0, bk_io=0; dout=A5, doe=1 and wait_n=1 one cycle after ack; return to IDLE when mreq_n rises.
- I/O write to port 16'h00FE, di=8'h3C -> bk_io=1, bk_we=1, bk_wdata=3C; no doe.
- irq_req=1, irq_vector=8'h42, INTA cycle -> int_n=0 after 1 cycle; dout=42, doe=1, wait_n never low; irq_ack one pulse.
- TIMEOUT=4, bk_ack never asserted -> bk_req drops after 4 REQ cycles; timeout pulse; dout=FF; CPU released.
- Also with TIMEOUT=4: bk_ack coincident with expiry -> data taken from the backend, no timeout pulse.
- wb_rst_i asserted mid-REQ with mreq_n held low -> outputs return to reset values immediately; after release, no bk_req until mreq_n goes high; the next cycle is served normally.
- Refresh cycle (mreq_n=0, rfsh_n=0), and MEM_MASK=FF00/MEM_MATCH=8000 with A=16'h1000 -> no bk_req, wait_n=1, doe=0.
